dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, the host/loader port, the data-memory port and the
// fractcore parameter handshake that dmem_arbiter sits in the middle of.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  logic        host_req;
  logic        host_we;
  logic [12:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;

  logic        f_memwrite;
  logic [12:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic        fc_idle;
  logic        f_paramload;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  readdata, fc_idle,
    output cpu_ack, cpu_rdata, host_ack, host_rdata,
    output f_memwrite, addr, writedata, f_paramload
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output readdata, fc_idle,
    input  cpu_ack, cpu_rdata, host_ack, host_rdata,
    input  f_memwrite, addr, writedata, f_paramload
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU and the host
// loader, plus the dirty tracking that tells fractcore to reload its parameters.
module dmem_arbiter (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GNT_CPU  = 2'd1;
  localparam logic [1:0] GNT_HOST = 2'd2;

  localparam logic LAST_CPU  = 1'b0;
  localparam logic LAST_HOST = 1'b1;

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic        last_reg;
  logic        dirty_reg;
  logic        started_reg;
  logic [31:0] cpu_rdata_reg;
  logic [31:0] host_rdata_reg;

  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_ack;
  logic        host_ack;
  logic        param_write;
  logic        paramload;

  always_comb begin
    state_next = IDLE;
    if (state_reg == IDLE) begin
      if (bus.cpu_req && bus.host_req)
        state_next = (last_reg == LAST_HOST) ? GNT_CPU : GNT_HOST;
      else if (bus.cpu_req)
        state_next = GNT_CPU;
      else if (bus.host_req)
        state_next = GNT_HOST;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    host_ack  = 1'b0;
    case (state_reg)
      GNT_CPU: begin
        mem_we    = bus.cpu_we;
        mem_addr  = bus.cpu_addr;
        mem_wdata = bus.cpu_wdata;
        cpu_ack   = 1'b1;
      end
      GNT_HOST: begin
        mem_we    = bus.host_we;
        mem_addr  = bus.host_addr;
        mem_wdata = bus.host_wdata;
        host_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  // Slots 29..31 hold the fractcore parameters; upper address bits alias.
  assign param_write = mem_we && (mem_addr[4:0] >= 5'd29);

  // started_reg keeps the post-reset load out of the reset period itself and
  // places it in the first full cycle after release.
  assign paramload = started_reg && dirty_reg && bus.fc_idle && !param_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_reg       <= LAST_HOST;
      dirty_reg      <= 1'b1;
      started_reg    <= 1'b0;
      cpu_rdata_reg  <= '0;
      host_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
      if (state_next == GNT_CPU)
        last_reg <= LAST_CPU;
      else if (state_next == GNT_HOST)
        last_reg <= LAST_HOST;
      if (param_write)
        dirty_reg <= 1'b1;
      else if (paramload)
        dirty_reg <= 1'b0;
      if (state_reg == GNT_CPU && !bus.cpu_we)
        cpu_rdata_reg <= bus.readdata;
      if (state_reg == GNT_HOST && !bus.host_we)
        host_rdata_reg <= bus.readdata;
    end
  end

  assign bus.f_memwrite  = mem_we;
  assign bus.addr        = mem_addr;
  assign bus.writedata   = mem_wdata;
  assign bus.cpu_ack     = cpu_ack;
  assign bus.host_ack    = host_ack;
  assign bus.cpu_rdata   = cpu_rdata_reg;
  assign bus.host_rdata  = host_rdata_reg;
  assign bus.f_paramload = paramload;

endmodule
